// File: rtl/operand_fetch_if.sv
// Handshake and writeback bundle between the decode/operand-fetch stage,
// its instruction source, the ALU and the result stage.
interface operand_fetch_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_src1;
    logic [WIDTH-1:0] out_src2;
    logic [3:0]       out_op;
    logic [4:0]       out_rd;
    logic             wb_en;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_src1, out_src2, out_op, out_rd
    );

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_src1, out_src2, out_op, out_rd
    );
endinterface

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: register file, busy scoreboard for RAW/WAW
// hazards, writeback bypass and the output pipeline register feeding the ALU.
module operand_fetch #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic           clk,
    input  logic           reset,
    operand_fetch_if.slave bus
);
    localparam int IDXW = 5;

    logic [3:0]      op;
    logic [IDXW-1:0] rd;
    logic [IDXW-1:0] rs1;
    logic [IDXW-1:0] rs2;
    logic            use_imm;
    logic [11:0]     imm12;

    assign {op, rd, rs1, rs2, use_imm, imm12} = bus.in_instr;

    logic [WIDTH-1:0] rf_reg [NREGS];
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_src1_reg;
    logic [WIDTH-1:0] out_src2_reg;
    logic [3:0]       out_op_reg;
    logic [IDXW-1:0]  out_rd_reg;

    logic             wb_hit_rs1;
    logic             wb_hit_rs2;
    logic             wb_hit_rd;
    logic             hazard;
    logic             in_ready_int;
    logic             accept;
    logic [WIDTH-1:0] src1_val;
    logic [WIDTH-1:0] src2_val;

    // A writeback landing this cycle resolves the matching busy bit early.
    assign wb_hit_rs1 = bus.wb_en && (bus.wb_rd == rs1);
    assign wb_hit_rs2 = bus.wb_en && (bus.wb_rd == rs2);
    assign wb_hit_rd  = bus.wb_en && (bus.wb_rd == rd);

    assign hazard = bus.in_valid &&
                    ((busy_reg[rs1] && !wb_hit_rs1) ||
                     (!use_imm && busy_reg[rs2] && !wb_hit_rs2) ||
                     ((rd != '0) && busy_reg[rd] && !wb_hit_rd));

    assign in_ready_int = (!out_valid_reg || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && in_ready_int;

    always_comb begin
        src1_val = '0;
        if (rs1 == '0)
            src1_val = '0;
        else if (wb_hit_rs1)
            src1_val = bus.wb_data;
        else
            src1_val = rf_reg[rs1];
    end

    always_comb begin
        src2_val = '0;
        if (use_imm)
            src2_val = {{(WIDTH-12){imm12[11]}}, imm12};
        else if (rs2 == '0)
            src2_val = '0;
        else if (wb_hit_rs2)
            src2_val = bus.wb_data;
        else
            src2_val = rf_reg[rs2];
    end

    // Per-register scoreboard update: an issuing write claim beats a same-cycle writeback.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        if (gi == 0) begin : g_r0
            assign busy_next[gi] = 1'b0;
        end else begin : g_rn
            assign busy_next[gi] = (accept && (rd == IDXW'(gi)))                  ? 1'b1 :
                                   (bus.wb_en && (bus.wb_rd == IDXW'(gi)))        ? 1'b0 :
                                   busy_reg[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                rf_reg[i] <= '0;
        end else if (bus.wb_en && (bus.wb_rd != '0)) begin
            rf_reg[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_src1_reg  <= '0;
            out_src2_reg  <= '0;
            out_op_reg    <= '0;
            out_rd_reg    <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_src1_reg  <= src1_val;
            out_src2_reg  <= src2_val;
            out_op_reg    <= op;
            out_rd_reg    <= rd;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_src1  = out_src1_reg;
    assign bus.out_src2  = out_src2_reg;
    assign bus.out_op    = out_op_reg;
    assign bus.out_rd    = out_rd_reg;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed scenarios followed by random traffic, all compared against a
// cycle-level reference model of the register file and scoreboard.
module tb_operand_fetch;
    logic clk;
    logic reset;

    operand_fetch_if #(.WIDTH(32)) bus ();

    operand_fetch #(.WIDTH(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model state
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          m_ov;
    logic [31:0] m_src1;
    logic [31:0] m_src2;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic ui, input logic [11:0] imm);
        return {op, rd, rs1, rs2, ui, imm};
    endfunction

    // A register blocks issue while busy unless its writeback arrives right now.
    function automatic bit blocked(input int r, input bit we, input int wrd);
        return m_busy[r] && !(we && (wrd == r));
    endfunction

    function automatic logic [31:0] operand(input int r, input bit we, input int wrd,
                                            input logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (we && (wrd == r)) return wd;
        return m_reg[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_ov   = 1'b0;
        m_src1 = 32'd0;
        m_src2 = 32'd0;
        m_op   = 4'd0;
        m_rd   = 5'd0;
    endtask

    // One clock cycle: drive, check in_ready mid-cycle, step model at the edge, check outputs.
    task automatic cyc(input bit rst, input bit iv, input logic [31:0] ins, input bit ordy,
                       input bit we, input logic [4:0] wrd, input logic [31:0] wd,
                       output bit rdy);
        int  op, rd, rs1, rs2;
        bit  ui, hz, exp_rdy, acc;
        logic [11:0] imm;
        reset         = rst;
        bus.in_valid  = iv;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.wb_en     = we;
        bus.wb_rd     = wrd;
        bus.wb_data   = wd;
        op  = int'(ins[31:28]);
        rd  = int'(ins[27:23]);
        rs1 = int'(ins[22:18]);
        rs2 = int'(ins[17:13]);
        ui  = ins[12];
        imm = ins[11:0];
        @(negedge clk);
        hz = iv && (blocked(rs1, we, int'(wrd)) ||
                    (!ui && blocked(rs2, we, int'(wrd))) ||
                    (rd != 0 && blocked(rd, we, int'(wrd))));
        exp_rdy = (!m_ov || ordy) && !hz;
        rdy = bus.in_ready;
        if (!rst) chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        acc = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            acc = iv && exp_rdy;
            if (acc) begin
                m_src1 = operand(rs1, we, int'(wrd), wd);
                m_src2 = ui ? 32'($signed(imm)) : operand(rs2, we, int'(wrd), wd);
                m_op   = 4'(op);
                m_rd   = 5'(rd);
                m_ov   = 1'b1;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (we) begin
                if (wrd != 5'd0) m_reg[wrd] = wd;
                m_busy[wrd] = 1'b0;
            end
            if (acc && rd != 0) m_busy[rd] = 1'b1;
        end
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
        chk("out_src1", bus.out_src1, m_src1);
        chk("out_src2", bus.out_src2, m_src2);
        chk("out_op", {28'd0, bus.out_op}, {28'd0, m_op});
        chk("out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
        if (acc)
            $display("issue t=%0t op=%h rd=%0d src1=%h src2=%h",
                     $time, bus.out_op, bus.out_rd, bus.out_src1, bus.out_src2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit r;
        logic [31:0] mul_i, add5_i;
        model_reset();

        // Reset state
        cyc(1, 0, 32'd0, 1, 0, 5'd0, 32'd0, r);
        cyc(1, 0, 32'd0, 1, 0, 5'd0, 32'd0, r);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_src1", bus.out_src1, 32'd0);
        chk("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);

        // ADD r1, r0, #10
        cyc(0, 1, mk(4'h0, 5'd1, 5'd0, 5'd0, 1'b1, 12'd10), 1, 0, 5'd0, 32'd0, r);
        chk("t1_ready", {31'd0, r}, 32'd1);
        chk("t1_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t1_src1", bus.out_src1, 32'd0);
        chk("t1_src2", bus.out_src2, 32'd10);
        chk("t1_op", {28'd0, bus.out_op}, 32'd0);
        chk("t1_rd", {27'd0, bus.out_rd}, 32'd1);
        cyc(0, 1, mk(4'h0, 5'd9, 5'd1, 5'd0, 1'b1, 12'd0), 1, 0, 5'd0, 32'd0, r);
        chk("t1_busy_r1", {31'd0, r}, 32'd0);

        // Writebacks then SUB r3, r1, r2
        cyc(0, 0, 32'd0, 1, 1, 5'd1, 32'd10, r);
        cyc(0, 0, 32'd0, 1, 1, 5'd2, 32'd5, r);
        cyc(0, 1, mk(4'h1, 5'd3, 5'd1, 5'd2, 1'b0, 12'd0), 1, 0, 5'd0, 32'd0, r);
        chk("t2_ready", {31'd0, r}, 32'd1);
        chk("t2_src1", bus.out_src1, 32'd10);
        chk("t2_src2", bus.out_src2, 32'd5);
        chk("t2_op", {28'd0, bus.out_op}, 32'd1);
        chk("t2_rd", {27'd0, bus.out_rd}, 32'd3);

        // MUL r4, r3, r3 stalls until r3 writes back, then bypasses
        mul_i = mk(4'h2, 5'd4, 5'd3, 5'd3, 1'b0, 12'd0);
        cyc(0, 1, mul_i, 1, 0, 5'd0, 32'd0, r);
        chk("t3_stall_a", {31'd0, r}, 32'd0);
        cyc(0, 1, mul_i, 1, 0, 5'd0, 32'd0, r);
        chk("t3_stall_b", {31'd0, r}, 32'd0);
        cyc(0, 1, mul_i, 1, 1, 5'd3, 32'd30, r);
        chk("t3_ready_wb", {31'd0, r}, 32'd1);
        chk("t3_src1", bus.out_src1, 32'd30);
        chk("t3_src2", bus.out_src2, 32'd30);
        chk("t3_op", {28'd0, bus.out_op}, 32'd2);
        chk("t3_rd", {27'd0, bus.out_rd}, 32'd4);

        // Output backpressure holds everything
        add5_i = mk(4'h0, 5'd5, 5'd0, 5'd0, 1'b1, 12'd7);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, add5_i, 0, 0, 5'd0, 32'd0, r);
            chk("t4_hold_ready", {31'd0, r}, 32'd0);
            chk("t4_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("t4_hold_src1", bus.out_src1, 32'd30);
            chk("t4_hold_rd", {27'd0, bus.out_rd}, 32'd4);
        end
        cyc(0, 1, add5_i, 1, 0, 5'd0, 32'd0, r);
        chk("t4_release_ready", {31'd0, r}, 32'd1);
        chk("t4_release_src2", bus.out_src2, 32'd7);
        chk("t4_release_rd", {27'd0, bus.out_rd}, 32'd5);

        // Negative immediate and r0 semantics
        cyc(0, 1, mk(4'h0, 5'd6, 5'd0, 5'd0, 1'b1, 12'hFFF), 1, 0, 5'd0, 32'd0, r);
        chk("t5_sext", bus.out_src2, 32'hFFFF_FFFF);
        cyc(0, 0, 32'd0, 1, 1, 5'd0, 32'h0000_1234, r);
        cyc(0, 1, mk(4'h0, 5'd7, 5'd0, 5'd0, 1'b0, 12'd0), 1, 0, 5'd0, 32'd0, r);
        chk("t5_r0_src1", bus.out_src1, 32'd0);
        chk("t5_r0_src2", bus.out_src2, 32'd0);
        cyc(0, 1, mk(4'h0, 5'd0, 5'd0, 5'd0, 1'b1, 12'd3), 1, 0, 5'd0, 32'd0, r);
        cyc(0, 1, mk(4'h0, 5'd8, 5'd0, 5'd0, 1'b0, 12'd0), 1, 0, 5'd0, 32'd0, r);
        chk("t5_r0_not_busy", {31'd0, r}, 32'd1);

        // Reset while busy and valid overrides a concurrent accept and writeback
        cyc(0, 1, mk(4'h0, 5'd3, 5'd0, 5'd0, 1'b1, 12'd1), 1, 0, 5'd0, 32'd0, r);
        chk("t6_pre_valid", {31'd0, bus.out_valid}, 32'd1);
        cyc(1, 1, mk(4'h0, 5'd9, 5'd0, 5'd0, 1'b1, 12'd5), 1, 1, 5'd2, 32'h0000_ABCD, r);
        chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_src2", bus.out_src2, 32'd0);
        cyc(0, 1, mk(4'h1, 5'd8, 5'd3, 5'd2, 1'b0, 12'd0), 1, 0, 5'd0, 32'd0, r);
        chk("t6_busy_cleared", {31'd0, r}, 32'd1);
        chk("t6_r3_zero", bus.out_src1, 32'd0);
        chk("t6_r2_zero", bus.out_src2, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int q[$];
            bit rst_b, iv_b, ordy_b, we_b;
            logic [4:0] wrd_v;
            logic [31:0] ins_v;
            for (int k = 1; k < 32; k++)
                if (m_busy[k]) q.push_back(k);
            rst_b  = ($urandom_range(0, 99) == 0);
            iv_b   = ($urandom_range(0, 9) < 7);
            ordy_b = ($urandom_range(0, 3) != 0);
            we_b   = ($urandom_range(0, 9) < 4);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                wrd_v = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                wrd_v = 5'($urandom_range(0, 31));
            ins_v = mk(4'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 1'($urandom), 12'($urandom));
            cyc(rst_b, iv_b, ins_v, ordy_b, we_b, wrd_v, $urandom, r);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
